// File: rtl/dsc_sector_cache_if.sv
// rtl/dsc_sector_cache_if.sv - request/response bundle for the decoupled sectored cache
interface dsc_sector_cache_if #(
  parameter int BLOCK_SIZE = 64
);
  logic                  read;
  logic                  write;
  logic [31:0]           addr;
  logic [BLOCK_SIZE-1:0] wdata;
  logic                  hit;
  logic [BLOCK_SIZE-1:0] rdata;

  modport master (output read, write, addr, wdata, input hit, rdata);
  modport slave  (input read, write, addr, wdata, output hit, rdata);
endinterface

// File: rtl/dsc_sector_cache.sv
// rtl/dsc_sector_cache.sv - decoupled sectored tag/data store; DSC_PERF_CNT_EN adds hit/miss counters
module dsc_sector_cache #(
  parameter int TAG_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int BLOCK_SIZE  = 64,
  parameter int NUM_WAYS    = 2,
  parameter int NUM_SECTORS = 2
) (
  input  logic               clk,
  input  logic               reset,
  dsc_sector_cache_if.slave  bus
`ifdef DSC_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);
  localparam int SB    = $clog2(NUM_SECTORS);
  localparam int WB    = $clog2(NUM_WAYS);
  localparam int NSETS = 2 ** INDEX_WIDTH;

  logic [TAG_WIDTH-1:0]  tag_q    [NSETS][NUM_WAYS];
  logic                  tag_v    [NSETS][NUM_WAYS];
  logic [WB-1:0]         tag_rr   [NSETS];
  logic                  frm_v    [NSETS][NUM_SECTORS][NUM_WAYS];
  logic [WB-1:0]         frm_own  [NSETS][NUM_SECTORS][NUM_WAYS];
  logic [BLOCK_SIZE-1:0] frm_data [NSETS][NUM_SECTORS][NUM_WAYS];
  logic [WB-1:0]         frm_rr   [NSETS][NUM_SECTORS];

  logic [TAG_WIDTH-1:0]   tag;
  logic [SB-1:0]          sec;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   unused_addr;

  assign tag = bus.addr[31:32-TAG_WIDTH];
  assign sec = bus.addr[4+SB-1:4];
  assign idx = bus.addr[4+SB+INDEX_WIDTH-1:4+SB];
  assign unused_addr = ^{bus.addr[3:0], bus.addr[31-TAG_WIDTH:4+SB+INDEX_WIDTH]};

  logic                  thit, inv_found, own_found, finv_found;
  logic [WB-1:0]         tway, inv_way, way_sel, own_frm, finv_frm, frm_sel;
  logic                  new_tag, adv_tag, adv_frm;
  logic                  rd_hit;
  logic [BLOCK_SIZE-1:0] rd_data;

  always_comb begin
    thit       = 1'b0;
    tway       = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    own_found  = 1'b0;
    own_frm    = '0;
    finv_found = 1'b0;
    finv_frm   = '0;
    rd_hit     = 1'b0;
    rd_data    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (tag_v[idx][w] && tag_q[idx][w] == tag && !thit) begin
        thit = 1'b1;
        tway = WB'(w);
      end
      if (!tag_v[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
    way_sel = thit ? tway : (inv_found ? inv_way : tag_rr[idx]);
    new_tag = !thit;
    adv_tag = !thit && !inv_found;
    for (int f = 0; f < NUM_WAYS; f++) begin
      if (thit && frm_v[idx][sec][f] && frm_own[idx][sec][f] == tway && !rd_hit) begin
        rd_hit  = 1'b1;
        rd_data = frm_data[idx][sec][f];
      end
      // Frames about to be cleared by a new tag allocation count as free here.
      if (frm_v[idx][sec][f] && frm_own[idx][sec][f] == way_sel && !new_tag && !own_found) begin
        own_found = 1'b1;
        own_frm   = WB'(f);
      end
      if (!(frm_v[idx][sec][f] && !(new_tag && frm_own[idx][sec][f] == way_sel)) && !finv_found) begin
        finv_found = 1'b1;
        finv_frm   = WB'(f);
      end
    end
    frm_sel = own_found ? own_frm : (finv_found ? finv_frm : frm_rr[idx][sec]);
    adv_frm = !own_found && !finv_found;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NSETS; s++) begin
        tag_rr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) tag_v[s][w] <= 1'b0;
        for (int c = 0; c < NUM_SECTORS; c++) begin
          frm_rr[s][c] <= '0;
          for (int f = 0; f < NUM_WAYS; f++) frm_v[s][c][f] <= 1'b0;
        end
      end
      bus.hit   <= 1'b0;
      bus.rdata <= '0;
    end else if (bus.write) begin
      if (new_tag) begin
        tag_v[idx][way_sel] <= 1'b1;
        for (int c = 0; c < NUM_SECTORS; c++)
          for (int f = 0; f < NUM_WAYS; f++)
            if (frm_own[idx][c][f] == way_sel) frm_v[idx][c][f] <= 1'b0;
      end
      frm_v[idx][sec][frm_sel] <= 1'b1;
      if (adv_tag) tag_rr[idx] <= tag_rr[idx] + WB'(1);
      if (adv_frm) frm_rr[idx][sec] <= frm_rr[idx][sec] + WB'(1);
    end else if (bus.read) begin
      bus.hit   <= rd_hit;
      bus.rdata <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && bus.write) begin
      tag_q[idx][way_sel]         <= tag;
      frm_own[idx][sec][frm_sel]  <= way_sel;
      frm_data[idx][sec][frm_sel] <= bus.wdata;
    end
  end

`ifdef DSC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (bus.read && !bus.write) begin
      if (rd_hit) hit_cnt <= hit_cnt + 32'd1;
      else        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dsc_sector_cache.sv
// tb/tb_dsc_sector_cache.sv - scoreboard bench for dsc_sector_cache
module tb_dsc_sector_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsc_sector_cache_if #(.BLOCK_SIZE(64)) bus ();

`ifdef DSC_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
  int exp_hits = 0, exp_misses = 0;
  dsc_sector_cache dut (.clk(clk), .reset(reset), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  dsc_sector_cache dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    string       name;
    logic        hit;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        last_hit = 1'b0;
  logic [63:0] last_data = '0;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_hold(input string name);
    check_val({name, ".hit"}, {63'd0, bus.hit}, {63'd0, last_hit});
    check_val({name, ".rdata"}, bus.rdata, last_data);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic eh, input logic [63:0] ed);
    exp_t e;
    @(negedge clk);
    bus.read  = 1'b1;
    bus.write = 1'b0;
    bus.addr  = a;
    sb.push_back('{name, eh, ed});
`ifdef DSC_PERF_CNT_EN
    if (eh) exp_hits++; else exp_misses++;
`endif
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    e = sb.pop_front();
    check_val({e.name, ".hit"}, {63'd0, bus.hit}, {63'd0, e.hit});
    check_val({e.name, ".rdata"}, bus.rdata, e.data);
    last_hit  = e.hit;
    last_data = e.data;
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [63:0] d, input logic also_read);
    @(negedge clk);
    bus.read  = also_read;
    bus.write = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    check_hold(name);
  endtask

  initial begin
    reset     = 1'b0;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.hit", {63'd0, bus.hit}, 64'd0);
    check_val("rst.rdata", bus.rdata, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_read("cold", 32'h0000_0000, 1'b0, 64'd0);
    do_write("w0", 32'h0000_0000, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
    do_read("r0", 32'h0000_0000, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    do_write("w1", 32'h0000_0010, 64'h1111_2222_3333_4444, 1'b0);
    do_read("r0b", 32'h0000_0000, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    do_read("r1", 32'h0000_0010, 1'b1, 64'h1111_2222_3333_4444);
    do_write("w2", 32'h1000_0000, 64'h5555_6666_7777_8888, 1'b0);
    do_read("r0c", 32'h0000_0000, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD);
    do_read("r2", 32'h1000_0000, 1'b1, 64'h5555_6666_7777_8888);
    do_read("r2s1", 32'h1000_0010, 1'b0, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_hold("idle");
    do_write("w3", 32'h2000_0000, 64'h9999_AAAA_BBBB_CCCC, 1'b0);
    do_read("ev0", 32'h0000_0000, 1'b0, 64'd0);
    do_read("ev1", 32'h0000_0010, 1'b0, 64'd0);
    do_read("keep", 32'h1000_0000, 1'b1, 64'h5555_6666_7777_8888);
    do_read("r3", 32'h2000_0000, 1'b1, 64'h9999_AAAA_BBBB_CCCC);
    do_read("r3s1", 32'h2000_0010, 1'b0, 64'd0);
    do_write("rw", 32'h0000_0020, 64'h0000_0000_0000_CAFE, 1'b1);
    do_read("cafe", 32'h0000_0020, 1'b1, 64'h0000_0000_0000_CAFE);
    do_read("set0", 32'h0000_0000, 1'b0, 64'd0);
    do_write("w4", 32'h1000_0020, 64'h0123_4567_89AB_CDEF, 1'b0);
    do_read("r4", 32'h1000_0020, 1'b1, 64'h0123_4567_89AB_CDEF);
    do_read("cafe2", 32'h0000_0020, 1'b1, 64'h0000_0000_0000_CAFE);
    do_write("w5", 32'h1000_0020, 64'hFEED_FACE_0000_0001, 1'b0);
    do_read("r5", 32'h1000_0020, 1'b1, 64'hFEED_FACE_0000_0001);

`ifdef DSC_PERF_CNT_EN
    check_val("hit_cnt", {32'd0, hit_cnt}, 64'(exp_hits));
    check_val("miss_cnt", {32'd0, miss_cnt}, 64'(exp_misses));
`endif

    @(negedge clk);
    reset     = 1'b0;
    bus.write = 1'b1;
    bus.addr  = 32'h3000_0000;
    bus.wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    check_val("mrst.hit", {63'd0, bus.hit}, 64'd0);
    check_val("mrst.rdata", bus.rdata, 64'd0);
`ifdef DSC_PERF_CNT_EN
    check_val("mrst.cnt", {hit_cnt, miss_cnt}, 64'd0);
    exp_hits   = 0;
    exp_misses = 0;
`endif
    @(negedge clk);
    reset = 1'b1;
    do_read("post1", 32'h1000_0000, 1'b0, 64'd0);
    do_read("post3", 32'h3000_0000, 1'b0, 64'd0);
    do_read("postc", 32'h0000_0020, 1'b0, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
